// File: rtl/check_pkg.sv
// Shared encodings for the check_multi result checker.
// FSM states, sc_cmd codes and meta-word bit positions.
package check_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_CMP  = 2'd2,
    S_WB   = 2'd3
  } state_e;

  localparam logic [4:0] CMD_NOP  = 5'd0;
  localparam logic [4:0] CMD_MASK = 5'd1;
  localparam logic [4:0] CMD_MODE = 5'd2;
  localparam logic [4:0] CMD_CLR  = 5'd3;

  localparam int META_FAIL    = 0;
  localparam int META_CYC_LSB = 1;

  function automatic int meta_tmo_bit(input int cr);
    return cr + 1;
  endfunction

  function automatic int meta_vld_bit(input int cr);
    return cr + 2;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// Holds at all ones once reached.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;

  // count up until all ones; reset and clear win
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/check_multi.sv
// Compares result vectors against expected vectors and writes records to memory.
// Define CHECK_MULTI_STATS_EN to build the pass/fail/timeout counters.
module check_multi
  import check_pkg::*;
#(
  parameter int ADDR_WIDTH  = 20,
  parameter int DATA_WIDTH  = 16,
  parameter int RTF_WIDTH   = 24,
  parameter int CYCLE_RANGE = 5,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  output logic [ADDR_WIDTH-1:0]             mem_address,
  output logic [DATA_WIDTH/8-1:0]           mem_byteenable,
  output logic                              mem_write,
  output logic [DATA_WIDTH-1:0]             mem_writedata,
  input  logic                              mem_waitrequest,
  input  logic [RTF_WIDTH+CYCLE_RANGE:0]    rfifo_data,
  output logic                              rfifo_rdreq,
  input  logic                              rfifo_rdempty,
  input  logic [RTF_WIDTH+ADDR_WIDTH-1:0]   cfifo_data,
  output logic                              cfifo_rdreq,
  input  logic                              cfifo_rdempty,
  input  logic [4:0]                        sc_cmd,
  input  logic [23:0]                       sc_data,
  output logic                              sc_ready,
  output logic [CNT_WIDTH-1:0]              pass_count,
  output logic [CNT_WIDTH-1:0]              fail_count,
  output logic [CNT_WIDTH-1:0]              timeout_count
);

  localparam int VEC_WORDS = (RTF_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int RES_WORDS = VEC_WORDS + 1;
  localparam int PW        = VEC_WORDS * DATA_WIDTH;
  localparam int IDX_W     = (RES_WORDS > 2) ? $clog2(RES_WORDS) : 1;
  localparam int TMO_BIT   = meta_tmo_bit(CYCLE_RANGE);
  localparam int VLD_BIT   = meta_vld_bit(CYCLE_RANGE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RES_WORDS - 1);
  localparam logic [IDX_W-1:0] META_IDX = IDX_W'(VEC_WORDS);

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [IDX_W-1:0]       idx_q;
  logic [RTF_WIDTH-1:0]   mask_q;
  logic [RTF_WIDTH-1:0]   res_q;
  logic                   mode_q;
  logic                   fail_q;
  logic                   tmo_q;
  logic [CYCLE_RANGE-1:0] cyc_q;

  logic [RTF_WIDTH-1:0]   r_res;
  logic [CYCLE_RANGE-1:0] r_cyc;
  logic                   r_tmo;
  logic [RTF_WIDTH-1:0]   c_exp;
  logic [ADDR_WIDTH-1:0]  c_addr;

  logic idle;
  logic pass_v;
  logic skip;
  logic accept;
  logic [PW-1:0]          pad;
  logic [DATA_WIDTH-1:0]  meta;
  logic [DATA_WIDTH-1:0]  word;

  assign {r_res, r_cyc, r_tmo} = rfifo_data;
  assign {c_exp, c_addr}       = cfifo_data;

  assign idle   = (state_q == S_IDLE);
  assign pass_v = !fail_q && !tmo_q;
  assign skip   = mode_q && pass_v;
  assign accept = (state_q == S_WB) && !mem_waitrequest;

  // state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!rfifo_rdempty && !cfifo_rdempty) begin
          state_d = S_RD;
        end
      end
      S_RD:  state_d = S_CMP;
      S_CMP: state_d = skip ? S_IDLE : S_WB;
      S_WB: begin
        if (accept && (idx_q == LAST_IDX)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // commands land only while idle
  always_ff @(posedge clock) begin
    if (reset) begin
      mask_q <= '1;
      mode_q <= 1'b0;
    end else if (idle) begin
      case (sc_cmd)
        CMD_MASK: mask_q <= RTF_WIDTH'(sc_data);
        CMD_MODE: mode_q <= sc_data[0];
        CMD_NOP:  ;
        default:  ;
      endcase
    end
  end

  // capture the popped pair; FIFO heads are valid during the pop cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      res_q  <= '0;
      fail_q <= 1'b0;
      tmo_q  <= 1'b0;
      cyc_q  <= '0;
    end else if (state_q == S_RD) begin
      res_q  <= r_res & mask_q;
      fail_q <= |((r_res ^ c_exp) & mask_q);
      tmo_q  <= r_tmo;
      cyc_q  <= r_cyc;
    end
  end

  // write address and word index
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q <= '0;
      idx_q  <= '0;
    end else if (state_q == S_RD) begin
      addr_q <= c_addr;
      idx_q  <= '0;
    end else if (accept) begin
      addr_q <= addr_q + ADDR_WIDTH'(1);
      idx_q  <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // record word select: MSB-aligned result words, then meta
  always_comb begin
    pad = '0;
    pad[PW-1 -: RTF_WIDTH] = res_q;
    meta = '0;
    meta[META_FAIL] = fail_q;
    meta[META_CYC_LSB +: CYCLE_RANGE] = cyc_q;
    meta[TMO_BIT] = tmo_q;
    meta[VLD_BIT] = 1'b1;
    word = '0;
    for (int i = 0; i < VEC_WORDS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        word = pad[PW-1-i*DATA_WIDTH -: DATA_WIDTH];
      end
    end
    if (idx_q == META_IDX) begin
      word = meta;
    end
  end

  assign mem_write      = (state_q == S_WB);
  assign mem_writedata  = mem_write ? word : '0;
  assign mem_address    = addr_q;
  assign mem_byteenable = '1;
  assign rfifo_rdreq    = (state_q == S_RD);
  assign cfifo_rdreq    = (state_q == S_RD);
  assign sc_ready       = idle && rfifo_rdempty && cfifo_rdempty;

`ifdef CHECK_MULTI_STATS_EN
  logic in_cmp;
  logic clr;

  assign in_cmp = (state_q == S_CMP);
  assign clr    = idle && (sc_cmd == CMD_CLR);

  sat_counter #(.WIDTH(CNT_WIDTH)) u_pass (
    .clk_i (clock),
    .rst_i (reset),
    .clr_i (clr),
    .inc_i (in_cmp && pass_v),
    .cnt_o (pass_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_fail (
    .clk_i (clock),
    .rst_i (reset),
    .clr_i (clr),
    .inc_i (in_cmp && fail_q),
    .cnt_o (fail_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_tmo (
    .clk_i (clock),
    .rst_i (reset),
    .clr_i (clr),
    .inc_i (in_cmp && tmo_q),
    .cnt_o (timeout_count)
  );
`else
  assign pass_count    = '0;
  assign fail_count    = '0;
  assign timeout_count = '0;
`endif

endmodule

// File: doc/check_multi.md
CHECK_MULTI -- requirements
Module: check_multi

Interface
REQ-001 Parameter ADDR_WIDTH, default 20, memory word address width.
REQ-002 Parameter DATA_WIDTH, default 16, memory data width; SHALL be >= CYCLE_RANGE+3.
REQ-003 Parameter RTF_WIDTH, default 24, result/expected vector width.
REQ-004 Parameter CYCLE_RANGE, default 5, cycle-count field width.
REQ-005 Parameter CNT_WIDTH, default 16, statistics counter width.
REQ-006 Localparams: VEC_WORDS = ceil(RTF_WIDTH/DATA_WIDTH); RES_WORDS = VEC_WORDS+1.
REQ-007 Ports (clock and reset first):
- clock, in, 1, sole clock; all logic on rising edge.
- reset, in, 1, synchronous, active-high.
- mem_address, out, ADDR_WIDTH, write word address.
- mem_byteenable, out, DATA_WIDTH/8, constant all ones.
- mem_write, out, 1, write strobe.
- mem_writedata, out, DATA_WIDTH, write data.
- mem_waitrequest, in, 1, slave stall.
- rfifo_data, in, RTF_WIDTH+CYCLE_RANGE+1, {result, cycles, timeout}.
- rfifo_rdreq, out, 1, result FIFO pop.
- rfifo_rdempty, in, 1, result FIFO empty.
- cfifo_data, in, RTF_WIDTH+ADDR_WIDTH, {expected, base address}.
- cfifo_rdreq, out, 1, check FIFO pop.
- cfifo_rdempty, in, 1, check FIFO empty.
- sc_cmd, in, 5, stimulus command.
- sc_data, in, 24, command argument.
- sc_ready, out, 1, block idle and both FIFOs empty.
- pass_count, fail_count, timeout_count, out, CNT_WIDTH each, statistics (REQ-025).

Function
REQ-008 States: IDLE, RD_FIFOS, CMP, WRITEBACK; no other states reachable.
REQ-009 IDLE -> RD_FIFOS when both FIFOs are non-empty; rfifo_rdreq and cfifo_rdreq SHALL be high exactly in RD_FIFOS, one cycle per vector.
REQ-010 RD_FIFOS -> CMP unconditionally; CMP registers fail = ((result ^ expected) & bitmask) != 0, timeout, cycles, and loads address from cfifo_data[ADDR_WIDTH-1:0].
REQ-011 CMP -> WRITEBACK, except in fail-only mode with fail=0 and timeout=0, where CMP -> IDLE and no write SHALL occur.
REQ-012 In WRITEBACK, mem_write = 1; each cycle with mem_waitrequest = 0 accepts one word, increments address and the word index; address, data and index SHALL hold while mem_waitrequest = 1.
REQ-013 WRITEBACK -> IDLE on acceptance of word index RES_WORDS-1; exactly RES_WORDS writes per written vector.
REQ-014 Words 0..VEC_WORDS-1 SHALL carry the masked result, MSB-aligned, MSB word first, zero-padded in the LSBs of the last vector word.
REQ-015 The meta word SHALL be bit0 = fail, bits[CYCLE_RANGE:1] = cycles, bit CYCLE_RANGE+1 = timeout, bit CYCLE_RANGE+2 = 1 (valid), all higher bits 0.
REQ-016 sc_cmd codes: 0 no-op; 1 load bitmask = sc_data[RTF_WIDTH-1:0]; 2 mode = sc_data[0] (1 = fail-only); 3 clear statistics.
REQ-017 Commands SHALL take effect only on a cycle with state = IDLE and are ignored otherwise; a command arriving on the same cycle as an IDLE -> RD_FIFOS transition SHALL still apply, before that vector's CMP.
REQ-018 sc_ready = (state == IDLE) & rfifo_rdempty & cfifo_rdempty, combinational.
REQ-019 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.
REQ-020 mem_writedata SHALL be 0 whenever mem_write = 0.

Reset
REQ-021 While reset is high, at the next edge: state = IDLE, address = 0, word index = 0, bitmask = all ones, mode = 0, counters = 0, fail/timeout/cycles registers = 0.
REQ-022 Outputs after reset: mem_write = 0, rfifo_rdreq = 0, cfifo_rdreq = 0, mem_writedata = 0, mem_address = 0.
REQ-023 Reset during WRITEBACK SHALL abort the vector; a partially written record is not completed, and no FIFO entry is re-read.

Configuration
REQ-024 Macro CHECK_MULTI_STATS_EN compiles in the statistics logic.
REQ-025 With the macro: in CMP, pass_count increments on fail=0 and timeout=0; fail_count increments on fail=1; timeout_count increments on timeout=1. Counters saturate at all ones and clear on command 3 or reset.
REQ-026 Without the macro: the three count ports SHALL exist and be tied to 0; no counter flops are synthesised.

Structure
REQ-027 Package check_pkg SHALL hold the state encoding, sc_cmd code constants and meta-word bit-position constants.
REQ-028 One sub-module, sat_counter (CNT_WIDTH, synchronous clear, increment enable, saturating), SHALL be instantiated three times under the macro.

Verification
REQ-029 Defaults, result = expected = 0xABCDEF, cycles = 3, timeout = 0, address 0x100 -> writes 0x100 = 0xABCD, 0x101 = 0xEF00, 0x102 = 0x0086; then sc_ready = 1.
REQ-030 Expected 0xABCD00, result 0xABCDFF -> meta 0x0087. After bitmask 0xFFFF00, the same pair -> meta 0x0086 and word 1 = 0x0000.
REQ-031 Mode 1 with a passing vector -> no mem_write and pass_count = 1. A subsequent failing vector -> 3 writes and fail_count = 1.
REQ-032 mem_waitrequest held high 4 cycles on word 1 -> mem_address and mem_writedata stable throughout, exactly 3 accepted writes, and the address ends at base+3.
REQ-033 Reset pulsed in WRITEBACK after word 0 -> mem_write = 0 next cycle, bitmask = 0xFFFFFF, counters = 0, and a subsequent vector writes correctly.
REQ-034 CNT_WIDTH = 4 with 20 failing vectors -> fail_count = 15; command 3 -> 0. Without the macro, all counts stay 0.
